// File: rtl/rv32im_alu_issue_pkg.sv
// Shared constants and types for the RV32IM ALU issue stage: opcodes, ALU op
// codes and the in-flight tracking entry.
package rv32im_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } track_t;

    // x0 is hard-wired, so it never creates a dependency.
    function automatic logic rs_match(input logic [4:0] rs, input track_t t);
        return (rs != 5'd0) && t.valid && (rs == t.rd);
    endfunction

endpackage

// File: rtl/rv32im_alu_issue_if.sv
// Fetch-to-issue instruction handshake: the fetch side is master, issue is slave.
interface rv32im_alu_issue_if;
    import rv32im_pkg::*;

    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            instr_valid;
    logic            instr_ready;

    modport master (output instr, pc, instr_valid, input instr_ready);
    modport slave  (input instr, pc, instr_valid, output instr_ready);
endinterface

// File: rtl/rv32im_imm_gen.sv
// Immediate extraction from the upper instruction bits: sign-extended I-type,
// U-type, and the zero-extended shift amount used by immediate shifts.
module rv32im_imm_gen
    import rv32im_pkg::*;
(
    input  logic [19:0]     instr_hi,   // instr[31:12]
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] shamt
);
    assign imm_i = {{(XLEN-12){instr_hi[19]}}, instr_hi[19:8]};
    assign imm_u = {instr_hi, 12'b0};
    assign shamt = {{(XLEN-5){1'b0}}, instr_hi[12:8]};
endmodule

// File: rtl/rv32im_alu_issue.sv
// Issue stage for the RV32IM integer ALU: decode, operand forwarding from the
// ALU result, one-cycle RAW stall against the instruction just issued.
module rv32im_alu_issue
    import rv32im_pkg::*;
(
    input  logic                clk_i,
    input  logic                clear_i,
    rv32im_alu_issue_if.slave   fetch,
    output logic [4:0]          rs1_addr_o,
    output logic [4:0]          rs2_addr_o,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    input  logic [XLEN-1:0]     alu_result_i,
    input  logic                flush_i,
    output logic [3:0]          operation_o,
    output logic [XLEN-1:0]     operand1_o,
    output logic [XLEN-1:0]     operand2_o,
    output logic                data_ready_o,
    output logic [4:0]          rd_o,
    output logic                rd_write_o,
    output logic                illegal_o
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [XLEN-1:0] imm_i, imm_u, shamt;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] op1_d, op2_d;
    logic [3:0]      op_d;
    logic            legal, use_rs1, use_rs2, hazard, accept;
    track_t          iss, ex;

    assign opcode     = fetch.instr[6:0];
    assign rd         = fetch.instr[11:7];
    assign funct3     = fetch.instr[14:12];
    assign funct7     = fetch.instr[31:25];
    assign rs1_addr_o = fetch.instr[19:15];
    assign rs2_addr_o = fetch.instr[24:20];

    rv32im_imm_gen u_imm_gen (
        .instr_hi (fetch.instr[31:12]),
        .imm_i    (imm_i),
        .imm_u    (imm_u),
        .shamt    (shamt)
    );

    // The register file is written at the end of the ALU-result cycle, so its
    // read data is stale for a source produced by the instruction in ex.
    assign rs1_val = rs_match(rs1_addr_o, ex) ? alu_result_i : rs1_data_i;
    assign rs2_val = rs_match(rs2_addr_o, ex) ? alu_result_i : rs2_data_i;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        op_d    = ALU_ADD;
        op1_d   = rs1_val;
        op2_d   = rs2_val;
        unique case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                op_d    = {funct7[5], funct3};
                legal   = (funct7 == 7'b0000000) ||
                          (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                op2_d   = imm_i;
                op_d    = {1'b0, funct3};
                legal   = 1'b1;
                if (funct3 == 3'b001) begin
                    op2_d = shamt;
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    op2_d = shamt;
                    op_d  = {fetch.instr[30], funct3};
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
            end
            OPC_LUI: begin
                legal = 1'b1;
                op1_d = '0;
                op2_d = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                op1_d = fetch.pc;
                op2_d = imm_u;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal words read no sources, so they never stall.
    assign hazard = legal && ((use_rs1 && rs_match(rs1_addr_o, iss)) ||
                              (use_rs2 && rs_match(rs2_addr_o, iss)));
    assign fetch.instr_ready = ~clear_i & ~flush_i & ~hazard;
    assign accept = fetch.instr_valid & fetch.instr_ready;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (clear_i) begin
            operation_o  <= '0;
            operand1_o   <= '0;
            operand2_o   <= '0;
            data_ready_o <= 1'b0;
            rd_o         <= '0;
            rd_write_o   <= 1'b0;
            illegal_o    <= 1'b0;
            iss          <= '0;
            ex           <= '0;
        end else begin
            data_ready_o <= 1'b0;
            illegal_o    <= 1'b0;
            iss          <= '0;
            ex           <= flush_i ? '0 : iss;
            if (accept) begin
                if (legal) begin
                    data_ready_o <= 1'b1;
                    operation_o  <= op_d;
                    operand1_o   <= op1_d;
                    operand2_o   <= op2_d;
                    rd_o         <= rd;
                    rd_write_o   <= (rd != 5'd0);
                    iss          <= track_t'{valid: 1'b1, rd: rd};
                end else begin
                    illegal_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rv32im_alu_issue.sv
// Directed self-checking bench for rv32im_alu_issue with hand-encoded RV32 words.
module tb_rv32im_alu_issue;
    import rv32im_pkg::*;

    localparam logic [31:0] ADDI_X1_X0_5  = 32'h0050_0093;
    localparam logic [31:0] ADD_X2_X1_X1  = 32'h0010_8133;
    localparam logic [31:0] SUB_X3_X4_X5  = 32'h4052_01B3;
    localparam logic [31:0] SRAI_X6_X7_4  = 32'h4043_D313;
    localparam logic [31:0] AUIPC_X8      = 32'h1234_5417;
    localparam logic [31:0] MUL_X1_X2_X3  = 32'h0231_00B3;
    localparam logic [31:0] ADDI_X0_X0_1  = 32'h0010_0013;
    localparam logic [31:0] ADD_X1_X0_X0  = 32'h0000_00B3;

    logic            clk_i = 1'b0;
    logic            clear_i;
    logic [4:0]      rs1_addr_o, rs2_addr_o;
    logic [XLEN-1:0] rs1_data_i, rs2_data_i, alu_result_i;
    logic            flush_i;
    logic [3:0]      operation_o;
    logic [XLEN-1:0] operand1_o, operand2_o;
    logic            data_ready_o, rd_write_o, illegal_o;
    logic [4:0]      rd_o;

    int n_checks = 0;
    int n_pass   = 0;

    rv32im_alu_issue_if fetch_if ();

    rv32im_alu_issue dut (
        .clk_i        (clk_i),
        .clear_i      (clear_i),
        .fetch        (fetch_if),
        .rs1_addr_o   (rs1_addr_o),
        .rs2_addr_o   (rs2_addr_o),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .alu_result_i (alu_result_i),
        .flush_i      (flush_i),
        .operation_o  (operation_o),
        .operand1_o   (operand1_o),
        .operand2_o   (operand2_o),
        .data_ready_o (data_ready_o),
        .rd_o         (rd_o),
        .rd_write_o   (rd_write_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] d1, input logic [31:0] d2);
        fetch_if.instr       = instr;
        fetch_if.pc          = pc;
        fetch_if.instr_valid = 1'b1;
        rs1_data_i           = d1;
        rs2_data_i           = d2;
        #1;
    endtask

    initial begin
        clear_i = 1'b1; flush_i = 1'b0;
        fetch_if.instr = '0; fetch_if.pc = '0; fetch_if.instr_valid = 1'b0;
        rs1_data_i = '0; rs2_data_i = '0; alu_result_i = '0;
        step(); step();
        check("rst_ready", 32'(fetch_if.instr_ready), 32'd0);
        check("rst_data_ready", 32'(data_ready_o), 32'd0);
        check("rst_illegal", 32'(illegal_o), 32'd0);
        check("rst_rd_write", 32'(rd_write_o), 32'd0);
        check("rst_operand1", operand1_o, 32'd0);
        clear_i = 1'b0;

        // addi x1,x0,5 followed by dependent add x2,x1,x1
        present(ADDI_X1_X0_5, 32'h0, 32'h0, 32'h0);
        check("addi_ready", 32'(fetch_if.instr_ready), 32'd1);
        step();
        check("addi_strobe", 32'(data_ready_o), 32'd1);
        check("addi_op", 32'(operation_o), 32'h0);
        check("addi_op1", operand1_o, 32'd0);
        check("addi_op2", operand2_o, 32'd5);
        check("addi_rd", 32'(rd_o), 32'd1);
        present(ADD_X2_X1_X1, 32'h4, 32'h77, 32'h77);
        check("raw_rs1_addr", 32'(rs1_addr_o), 32'd1);
        check("raw_stall", 32'(fetch_if.instr_ready), 32'd0);
        step();
        check("bubble_strobe", 32'(data_ready_o), 32'd0);
        alu_result_i = 32'd5;
        #1;
        check("raw_resume", 32'(fetch_if.instr_ready), 32'd1);
        step();
        check("fwd_strobe", 32'(data_ready_o), 32'd1);
        check("fwd_op1", operand1_o, 32'd5);
        check("fwd_op2", operand2_o, 32'd5);
        check("fwd_rd", 32'(rd_o), 32'd2);

        // sub x3,x4,x5
        present(SUB_X3_X4_X5, 32'h8, 32'd10, 32'd3);
        step();
        check("sub_op", 32'(operation_o), 32'h8);
        check("sub_op1", operand1_o, 32'd10);
        check("sub_op2", operand2_o, 32'd3);
        check("sub_rd", 32'(rd_o), 32'd3);
        check("sub_rd_write", 32'(rd_write_o), 32'd1);

        // srai x6,x7,4
        present(SRAI_X6_X7_4, 32'hC, 32'h8000_0000, 32'h0);
        step();
        check("srai_op", 32'(operation_o), 32'hD);
        check("srai_op1", operand1_o, 32'h8000_0000);
        check("srai_op2", operand2_o, 32'd4);

        // auipc x8,0x12345 at pc 0x100
        present(AUIPC_X8, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step();
        check("auipc_op", 32'(operation_o), 32'h0);
        check("auipc_op1", operand1_o, 32'h100);
        check("auipc_op2", operand2_o, 32'h1234_5000);
        check("auipc_rd", 32'(rd_o), 32'd8);

        // mul is outside the supported subset
        present(MUL_X1_X2_X3, 32'h104, 32'd1, 32'd2);
        check("mul_ready", 32'(fetch_if.instr_ready), 32'd1);
        step();
        check("mul_illegal", 32'(illegal_o), 32'd1);
        check("mul_no_strobe", 32'(data_ready_o), 32'd0);
        check("mul_rd_held", 32'(rd_o), 32'd8);
        fetch_if.instr_valid = 1'b0;
        step();
        check("mul_pulse_end", 32'(illegal_o), 32'd0);

        // writes to x0 create no dependency
        present(ADDI_X0_X0_1, 32'h108, 32'h0, 32'h0);
        step();
        check("x0_strobe", 32'(data_ready_o), 32'd1);
        check("x0_rd_write", 32'(rd_write_o), 32'd0);
        alu_result_i = 32'h0000_0BAD;
        present(ADD_X1_X0_X0, 32'h10C, 32'h0, 32'h0);
        check("x0_no_stall", 32'(fetch_if.instr_ready), 32'd1);
        step();
        check("x0_add_strobe", 32'(data_ready_o), 32'd1);
        check("x0_add_op1", operand1_o, 32'd0);
        check("x0_add_rd_write", 32'(rd_write_o), 32'd1);

        // flush while addi x1 is in iss
        present(ADDI_X1_X0_5, 32'h200, 32'h0, 32'h0);
        step();
        check("pre_flush_strobe", 32'(data_ready_o), 32'd1);
        present(ADD_X2_X1_X1, 32'h204, 32'h7, 32'h7);
        flush_i = 1'b1;
        #1;
        check("flush_ready", 32'(fetch_if.instr_ready), 32'd0);
        step();
        check("flush_strobe", 32'(data_ready_o), 32'd0);
        flush_i = 1'b0;
        alu_result_i = 32'd5;
        #1;
        check("post_flush_ready", 32'(fetch_if.instr_ready), 32'd1);
        step();
        check("post_flush_strobe", 32'(data_ready_o), 32'd1);
        check("post_flush_op1", operand1_o, 32'd7);
        check("post_flush_op2", operand2_o, 32'd7);

        // clear mid-stream drops everything
        present(ADDI_X1_X0_5, 32'h300, 32'h0, 32'h0);
        step();
        fetch_if.instr_valid = 1'b0;
        clear_i = 1'b1;
        step();
        check("clr_strobe", 32'(data_ready_o), 32'd0);
        check("clr_rd", 32'(rd_o), 32'd0);
        check("clr_op2", operand2_o, 32'd0);
        clear_i = 1'b0;
        present(ADD_X2_X1_X1, 32'h304, 32'd9, 32'd9);
        check("clr_no_stall", 32'(fetch_if.instr_ready), 32'd1);
        step();
        check("clr_add_op1", operand1_o, 32'd9);
        fetch_if.instr_valid = 1'b0;
        step();
        check("idle_strobe", 32'(data_ready_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rv32im_alu_issue.md
# rv32im_alu_issue

Issue stage that feeds the RV32IM integer ALU. It accepts one instruction word per cycle over a valid/ready handshake and drives the register-file read addresses. It decodes the instruction into the ALU's 4-bit operation code and two operands, then presents them to the ALU on a registered `data_ready_o` strobe. It also tracks the two instructions in flight, forwarding the ALU result or stalling on read-after-write hazards.

## Interface
- `XLEN`, 32, datapath width.
- `clk_i`  in  1  clock, all logic on rising edge.
- `clear_i`  in  1  reset; synchronous and active-high.
- `instr_i`  in  32  instruction word.
- `pc_i`  in  XLEN  address of `instr_i`.
- `instr_valid_i`  in  1  `instr_i`/`pc_i` valid.
- `instr_ready_o`  out  1  combinational; transfer occurs when `instr_valid_i & instr_ready_o`.
- `rs1_addr_o`, `rs2_addr_o`  out  5  combinational from `instr_i[19:15]`, `instr_i[24:20]`.
- `rs1_data_i`, `rs2_data_i`  in  XLEN  register file read data, same cycle.
- `alu_result_i`  in  XLEN  ALU registered result.
- `flush_i`  in  1  branch redirect; discard in-flight work.
- `operation_o`  out  4  ALU op code.
- `operand1_o`, `operand2_o`  out  XLEN  ALU operands.
- `data_ready_o`  out  1  one-cycle strobe per issued instruction.
- `rd_o`  out  5  destination of the issued instruction.
- `rd_write_o`  out  1  issued instruction writes `rd_o`; 0 when `rd`=x0.
- `illegal_o`  out  1  one-cycle pulse: accepted word was not decodable.

## Operation
- ALU op codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111. Generally `operation = {b3, funct3}`.
- OP (0110011):
  - funct7 0000000 gives `b3`=0.
  - funct7 0100000 gives `b3`=1; legal only with funct3 000 or 101.
  - Any other funct7, including M-extension 0000001, is illegal.
  - Operands are rs1 and rs2.
- OP-IMM (0010011):
  - operand2 = sign-extended I-immediate; `b3`=0.
  - Shifts (funct3 001/101) use `instr[24:20]` as the shift amount.
  - SRAI sets `b3`=1 when `instr[30]`=1.
  - Shift funct7 other than 0000000/0100000 (SLLI only 0000000) is illegal.
- LUI (0110111): op ADD, operand1 = 0, operand2 = `{instr[31:12], 12'b0}`.
- AUIPC (0010111): op ADD, operand1 = `pc_i`, operand2 = U-immediate.
- Any other opcode is illegal.
- Illegal words are accepted (consumed), pulse `illegal_o` next cycle, and produce no `data_ready_o`.
- Tracking registers:
  - `iss` holds the rd/valid of the instruction currently on `data_ready_o`.
  - `ex` holds the rd/valid of the instruction whose result is on `alu_result_i` this cycle.
  - Each cycle `ex <= iss`; `iss <=` the newly issued instruction, or invalid.
- Forwarding: a source rs (nonzero, used by the instruction) equal to `ex.rd` with `ex` valid takes `alu_result_i` instead of register data. The register file is written at the end of that cycle, so its data is stale.
- Hazard stall: a used source rs (nonzero) equal to `iss.rd` with `iss` valid drives `instr_ready_o` low.
  - `iss` becomes invalid next cycle, so that cycle is a bubble.
  - The following cycle forwards from `ex`. A stall therefore lasts exactly 1 cycle.
- x0 never matches for hazards or forwarding. LUI/AUIPC use no sources.
- `flush_i`:
  - The next cycle has `data_ready_o`=0.
  - `iss` and `ex` are invalidated.
  - `instr_ready_o`=0 during the flush cycle; any word presented that cycle is not consumed.

## Timing
- Issue latency is 1: a word accepted on edge N drives `data_ready_o`=1 with its operands during cycle N+1. The ALU result appears on `alu_result_i` in cycle N+2.
- Throughput is 1/cycle with no dependency; 1/2 cycles for back-to-back dependent pairs.
- `clear_i` (takes priority over `flush_i`) makes all registered outputs 0 after the edge and `iss`/`ex` invalid. `instr_ready_o`=0 while `clear_i`=1; it is otherwise `~flush_i & ~hazard`.
- Asserting `clear_i` mid-stream drops both in-flight instructions. No partial state survives.
- Outputs other than `data_ready_o`/`illegal_o` hold their last values when no instruction is issued; consumers must qualify on the strobe.

## Structure
- Package `rv32im_pkg`: opcode constants (OP, OP_IMM, LUI, AUIPC), ALU op localparams, tracking-entry typedef {valid, rd[4:0]}.
- Sub-module `rv32im_imm_gen`: combinational I/U immediate extraction and sign extension.
- Hazard/forward compare logic and the output register stay in the top.

## Test plan
- `addi x1,x0,5` then `add x2,x1,x1` back-to-back:
  - First word issues op 0000, operands 0/5.
  - `instr_ready_o` drops for 1 cycle.
  - `add` issues with both operands = `alu_result_i` (5).
- `sub x3,x4,x5` with rs data 10/3 issues op 1000, operands 10/3, `rd_o`=3, `rd_write_o`=1.
- `srai x6,x7,4` issues op 1101, operand2=4. `auipc x8,0x12345` with `pc_i`=0x100 issues op 0000, operands 0x100/0x12345000.
- `mul x1,x2,x3` (funct7 0000001) produces `illegal_o`=1 for 1 cycle, no `data_ready_o`, `instr_ready_o` stays 1.
- `addi x0,x0,1` then `add x1,x0,x0` has no stall; the first issue has `rd_write_o`=0.
- `flush_i` while an instruction is in `iss` gives `data_ready_o`=0 next cycle. The subsequent dependent word issues without stall, using register-file data.
